msk_permlinv_seq: RTL and testbench
===================================

MSK_PERMLINV_SEQ -- requirements
Module: MSK_PermLinv_seq

Interface
REQ-001 SHALL have parameter d, default 2, giving the number of Boolean shares per state bit (d >= 1).
REQ-002 SHALL have localparam W = 64, giving the Ascon lane width; it is not overridable.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to load in_state and begin an operation.
REQ-006 SHALL have port inverse, input, 1 bit, sampled with start: 1 selects the inverse linear layer, 0 selects the forward linear layer.
REQ-007 SHALL have port in_state, input, 5*W*d bits: masked Ascon state, sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-009 SHALL have port out_valid, output, 1 bit: high while out_state holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer acknowledge for out_state.
REQ-011 SHALL have port out_state, output, 5*W*d bits: masked result, driven directly from the state register.

Function
REQ-012 SHALL use this bus layout: lane x0 in bits [5Wd-1:4Wd] through lane x4 in bits [Wd-1:0]; within a lane, share j of bit i sits at index i*d+j.
REQ-013 SHALL define one step of Sigma as xk ^= ror(xk,a) ^ ror(xk,b) per lane, applied to each share independently; a rotation by r bits is a rotation of the lane bus by r*d positions.
REQ-014 SHALL use these rotation pairs (a,b): x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
REQ-015 SHALL realise the inverse as 63 applications of Sigma, because Sigma^64 = identity for every lane; no other inverse datapath is permitted.
REQ-016 SHALL implement exactly one combinational Sigma instance, feeding back into a 5*W*d state register; no share mixing and no randomness.
REQ-017 SHALL have three FSM states: IDLE, RUN, DONE.
REQ-018 In IDLE, when start=1: load in_state into the register, latch inverse, load the step counter with 62 (inverse) or 0 (forward), and go to RUN.
REQ-019 In RUN, every cycle: apply Sigma to the register and decrement the counter; when the counter equals 0, go to DONE.
REQ-020 Latency SHALL be: load on edge N; result valid after edge N+63 (inverse) or N+1 (forward).
REQ-021 In DONE, out_valid=1 and out_state is held stable; when out_ready=1, go to IDLE (out_valid falls on the next edge).
REQ-022 busy SHALL be 1 exactly in RUN; out_valid SHALL be 1 exactly in DONE.
REQ-023 start SHALL be ignored in RUN and DONE; a new operation is accepted only in IDLE, at the earliest the cycle after the out_ready handshake.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 The counter SHALL be 6 bits and SHALL never wrap below 0.

Reset
REQ-026 When rst_n=0 at a clock edge: FSM goes to IDLE; busy=0, out_valid=0, the state register is all zeros, and the counter is 0.
REQ-027 Reset SHALL take priority over start, over RUN iteration, and over out_ready; reset during RUN aborts the operation and the partial result is discarded.
REQ-028 After reset deassertion, the first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-029 Forward test, d=2: x0 share0 = 0x0000000000000001, all else 0, inverse=0 -> after 1 RUN cycle x0 share0 = 0x0000201000000001, other shares and lanes 0.
REQ-030 Round trip: random masked state S; forward, then inverse on the result -> final state equals S bit-exactly; busy high for exactly 63 cycles during the inverse.
REQ-031 Share independence: random shares, inverse=1 -> the XOR of the output shares equals the unmasked inverse of the XOR of the input shares, and each share equals the inverse of that share alone.
REQ-032 Handshake: hold out_ready=0 for 10 cycles in DONE, and pulse start during RUN and DONE -> out_state stays stable, the start pulses have no effect, and IDLE is reached one edge after out_ready=1.
REQ-033 Reset mid-RUN: assert rst_n=0 at RUN step 30 -> next edge busy=0, out_valid=0, register all zeros; a fresh start then completes normally.
REQ-034 Zero state, inverse=1 -> out_state all zeros, out_valid asserted after edge N+63.

Source files
------------

// File: rtl/msk_permlinv_seq.sv
// Sequential masked Ascon linear layer (Sigma) with inverse via 63 Sigma steps.
// One combinational Sigma instance iterates over a 5-lane, d-share state register.
module msk_permlinv_seq #(
  parameter int d = 2,
  localparam int W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inverse,
  input  logic [5*W*d-1:0] in_state,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5*W*d-1:0] out_state,
  output logic [1:0]       dbg_state,
  output logic             dbg_inv
);

  localparam int LW = W * d;
  localparam int SW = 5 * LW;

  // Handshake: out_valid is high exactly in DONE and out_state is held stable
  // there; the result is consumed on the first edge where out_valid && out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          fsm_q, fsm_d;
  logic [SW-1:0]   state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            inv_q, inv_d;
  logic [SW-1:0]   sigma;

  // Rotating a lane by r bits moves every share together: r*d bus positions.
  function automatic logic [LW-1:0] ror_lane(input logic [LW-1:0] x, input int r);
    return (x >> (r * d)) | (x << (LW - r * d));
  endfunction

  for (genvar k = 0; k < 5; k++) begin : g_lane
    localparam int RA = (k == 0) ? 19 : (k == 1) ? 61 : (k == 2) ? 1 : (k == 3) ? 10 : 7;
    localparam int RB = (k == 0) ? 28 : (k == 1) ? 39 : (k == 2) ? 6 : (k == 3) ? 17 : 41;
    logic [LW-1:0] x;
    assign x = state_q[(4-k)*LW +: LW];
    assign sigma[(4-k)*LW +: LW] = x ^ ror_lane(x, RA) ^ ror_lane(x, RB);
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = in_state;
          inv_d   = inverse;
          cnt_d   = inverse ? 6'd62 : 6'd0;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = sigma;
        if (cnt_q == 6'd0) begin
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  assign busy      = (fsm_q == S_RUN);
  assign out_valid = (fsm_q == S_DONE);
  assign out_state = state_q;
  assign dbg_state = fsm_q;
  assign dbg_inv   = inv_q;

endmodule

// File: tb/tb_msk_permlinv_seq.sv
// Bench for msk_permlinv_seq: random masked states checked against a per-share
// 64-bit lane model of Sigma, plus handshake, reset-abort and boundary cases.
module tb_msk_permlinv_seq;

  localparam int D  = 2;
  localparam int W  = 64;
  localparam int LW = W * D;
  localparam int SW = 5 * LW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          inverse;
  logic [SW-1:0] in_state;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic [1:0]    dbg_state;
  logic          dbg_inv;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SW-1:0] exp_q[$];

  msk_permlinv_seq #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
    .in_state(in_state), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state),
    .dbg_state(dbg_state), .dbg_inv(dbg_inv)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (per share, plain 64-bit lanes) -------
  function automatic int rot_a(input int k);
    int t[5] = '{19, 61, 1, 10, 7};
    return t[k];
  endfunction

  function automatic int rot_b(input int k);
    int t[5] = '{28, 39, 6, 17, 41};
    return t[k];
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic logic [63:0] sig64(input logic [63:0] x, input int k);
    return x ^ ror64(x, rot_a(k)) ^ ror64(x, rot_b(k));
  endfunction

  function automatic logic [63:0] get_lane(input logic [SW-1:0] s, input int k, input int j);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = s[(4-k)*LW + i*D + j];
    return r;
  endfunction

  function automatic logic [SW-1:0] put_lane(input logic [SW-1:0] s, input int k, input int j,
                                             input logic [63:0] v);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < 64; i++) r[(4-k)*LW + i*D + j] = v[i];
    return r;
  endfunction

  function automatic logic [SW-1:0] model_op(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] r;
    logic [63:0]   x;
    r = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < D; j++) begin
        x = get_lane(s, k, j);
        for (int n = 0; n < (inv ? 63 : 1); n++) x = sig64(x, k);
        r = put_lane(r, k, j, x);
      end
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [SW-1:0] s, input logic inv, input int hold,
                        input bit pulse, output logic [SW-1:0] res);
    int cyc;
    logic [SW-1:0] e;
    exp_q.push_back(model_op(s, inv));
    in_state = s;
    inverse  = inv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_load", busy, 1);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (pulse) begin
        start    = cyc[0];
        inverse  = ~inv;
        in_state = rand_state();
      end
      cyc++;
      tick();
    end
    check("busy_cycles", cyc, inv ? 63 : 1);
    check("valid_done", out_valid, 1);
    e = exp_q.pop_front();
    check("result", out_state, e);
    res = out_state;
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        start    = h[0];
        in_state = rand_state();
      end
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_stable", out_state, e);
      check("hold_not_busy", busy, 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_state", dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [SW-1:0] s, r1, r2, xin, xout;
    logic [63:0]   u;

    rst_n = 1'b0; start = 1'b0; inverse = 1'b0; in_state = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_state", out_state, '0);

    // Reset wins over start on the same edge.
    start = 1'b1; in_state = rand_state();
    tick();
    check("rst_vs_start", dbg_state, 0);
    start = 1'b0;
    rst_n = 1'b1;

    // Single set bit in x0 share0, forward: fixed expected value.
    s = '0;
    s[4*LW] = 1'b1;
    run_op(s, 1'b0, 0, 1'b0, r1);
    r2 = '0;
    r2 = put_lane(r2, 0, 0, 64'h0000201000000001);
    check("fwd_known", r1, r2);

    // out_ready in IDLE is ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_in_idle", dbg_state, 0);

    // Round trips on random states.
    for (int t = 0; t < 3; t++) begin
      s = rand_state();
      run_op(s, 1'b0, 0, 1'b0, r1);
      run_op(r1, 1'b1, 0, 1'b0, r2);
      check("round_trip", r2, s);
    end

    // Share independence: unmasked inverse of XORed shares.
    s = rand_state();
    run_op(s, 1'b1, 0, 1'b0, r1);
    for (int k = 0; k < 5; k++) begin
      xin = '0; xout = '0;
      u = get_lane(s, k, 0) ^ get_lane(s, k, 1);
      for (int n = 0; n < 63; n++) u = sig64(u, k);
      check("share_xor", get_lane(r1, k, 0) ^ get_lane(r1, k, 1), u);
      check("sigma_undoes", sig64(get_lane(r1, k, 1), k), get_lane(s, k, 1));
    end

    // Handshake: hold DONE for 10 cycles, pulse start in RUN and DONE.
    s = rand_state();
    run_op(s, 1'b1, 10, 1'b1, r1);

    // Reset at RUN step 30 aborts.
    in_state = rand_state(); inverse = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_state", out_state, '0);
    rst_n = 1'b1;
    s = rand_state();
    run_op(s, 1'b1, 0, 1'b0, r1);

    // Zero state inverse.
    run_op('0, 1'b1, 0, 1'b0, r1);
    check("zero_inv", r1, '0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_leftover obs=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
